// File: rtl/fifo.sv
// Synchronous single-clock FIFO used as the word buffer between the operand
// feeders and the systolic-array PEs. One push and one pop per cycle. Read
// data is registered, so it appears one cycle after the accepting edge.
// Optional build macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo #(
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_CAP   = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  w_enable,
  input  logic                  r_enable,
  input  logic [WORD_WIDTH-1:0] d_in,
  output logic                  full,
  output logic                  empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [WORD_WIDTH-1:0] d_out
);

  localparam logic [PTR_WIDTH:0] CAP_CNT = (PTR_WIDTH+1)'(FIFO_CAP);

  logic [WORD_WIDTH-1:0] mem [FIFO_CAP];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status flags and request qualification, all decoded from the occupancy.
  always_comb begin
    full  = (count == CAP_CNT);
    empty = (count == '0);
    wr_ok = w_enable & ~full;
    rd_ok = r_enable & ~empty;
  end

  // Storage array; never cleared, and a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset_n) begin
      mem[wr_ptr] <= d_in;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      d_out  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        d_out  <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags: any rejected request latches until reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_enable && full) begin
        overflow <= 1'b1;
      end
      if (r_enable && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: a queue-based reference model predicts the
// post-edge outputs of every cycle; a monitor compares them at the falling edge.
module tb_fifo;

  localparam int WW  = 8;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          w_enable;
  logic          r_enable;
  logic [WW-1:0] d_in;
  logic          full;
  logic          empty;
  logic [WW-1:0] d_out;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo #(.WORD_WIDTH(WW), .FIFO_CAP(CAP), .PTR_WIDTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .w_enable (w_enable),
    .r_enable (r_enable),
    .d_in     (d_in),
    .full     (full),
    .empty    (empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .d_out    (d_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] dout;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t          exp_q[$];
  logic [WW-1:0] model_q[$];
  logic [WW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // One clock cycle: drive inputs, advance the model, record the expected outcome.
  task automatic step(input logic rst, input logic w, input logic r, input logic [WW-1:0] d);
    exp_t e;
    logic m_full;
    logic m_empty;
    reset_n  = rst;
    w_enable = w;
    r_enable = r;
    d_in     = d;
    if (rst) begin
      model_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_full  = (model_q.size() == CAP);
      m_empty = (model_q.size() == 0);
      if (w && m_full)  m_ovf = 1'b1;
      if (r && m_empty) m_unf = 1'b1;
      if (r && !m_empty) m_dout = model_q.pop_front();
      if (w && !m_full)  model_q.push_back(d);
    end
    e.dout  = m_dout;
    e.full  = (model_q.size() == CAP);
    e.empty = (model_q.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: every cycle's outputs are compared against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("d_out", 32'(d_out), 32'(e.dout));
      check("full",  32'(full),  32'(e.full));
      check("empty", 32'(empty), 32'(e.empty));
`ifdef FIFO_ERR_FLAGS_EN
      check("overflow",  32'(overflow),  32'(e.ovf));
      check("underflow", 32'(underflow), 32'(e.unf));
`endif
    end
  end

  initial begin
    int pw;
    int pr;
    reset_n = 1'b1; w_enable = 1'b0; r_enable = 1'b0; d_in = '0;
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Ordering of three words, then read past empty.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 8'd3);
    step(0, 1, 0, 8'd2);
    step(0, 1, 0, 8'd1);
    repeat (4) step(0, 0, 1, 0);

    // Fill to full, rejected write, drain.
    step(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hAA);
    step(0, 1, 1, 8'hAB);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0);

    // Pointer wrap-around.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);

    // Simultaneous read and write at occupancy 5.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h50 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'(8'h60 + i));
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);

    // Simultaneous write and read on an empty FIFO: no fall-through.
    step(0, 1, 1, 8'h77);
    step(0, 0, 1, 0);

    // Mid-operation reset, then a read of the emptied FIFO.
    for (int i = 0; i < 7; i++) step(0, 1, 0, 8'(8'h90 + i));
    step(1, 1, 1, 8'hEE);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Error-flag behaviour (only observable when the flags exist).
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 8'h01);
    step(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'hC0 + i));
    step(0, 1, 0, 8'hFF);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Randomised phases with varying write/read bias to visit full and empty.
    for (int ph = 0; ph < 8; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 25;
      pr = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 99) < pw),
             ($urandom_range(0, 99) < pr),
             8'($urandom));
      end
    end

    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
